// File: rtl/kmeans_pass_ctrl_k3_d4.sv
// kmeans_pass_ctrl_k3_d4
// Runs one k-means assignment pass over the 3-centroid, 4-dimension distance
// pipeline. Points enter on a valid/ready stream and are registered into the
// pipeline input. The pipeline has no valid signal, so a delay line follows
// each point through it. Results that the delay line marks as valid are added
// into per-centroid coordinate sums and member counts.
module kmeans_pass_ctrl_k3_d4 #(
    parameter int input_data_width  = 16,
    parameter int centroid_id_width = 2,
    parameter int pipe_latency      = 6,
    parameter int count_width       = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [count_width-1:0]            num_points,
    input  logic                              pt_valid,
    output logic                              pt_ready,
    input  logic [4*input_data_width-1:0]     pt_data,
    output logic [4*input_data_width-1:0]     pipe_in_data,
    input  logic [4*input_data_width-1:0]     pipe_out_data,
    input  logic [centroid_id_width-1:0]      pipe_sel,
    output logic                              busy,
    output logic                              done,
    output logic                              err_sel,
    output logic [12*(input_data_width+count_width)-1:0] acc_sum,
    output logic [3*count_width-1:0]          acc_count
);

    // Sum width follows from the point width and the largest possible count.
    localparam int sum_width = input_data_width + count_width;
    // One stage for the pipe_in_data register, plus the pipeline itself.
    localparam int dly_depth = pipe_latency + 1;

    localparam logic [centroid_id_width-1:0] sel_max   = centroid_id_width'(2);
    localparam logic [count_width-1:0]       cnt_zero  = {count_width{1'b0}};
    localparam logic [count_width-1:0]       cnt_one   = {{(count_width-1){1'b0}}, 1'b1};
    localparam logic [sum_width-1:0]         sum_zero  = {sum_width{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [count_width-1:0]          num_q, num_d;
    logic [count_width-1:0]          issued_q, issued_d;
    logic [count_width-1:0]          retired_q, retired_d;
    logic [dly_depth-1:0]            dly_q, dly_d;
    logic [4*input_data_width-1:0]   pipe_in_data_q, pipe_in_data_d;
    logic [12*sum_width-1:0]         acc_sum_q, acc_sum_d;
    logic [3*count_width-1:0]        acc_count_q, acc_count_d;
    logic                            pt_ready_q, pt_ready_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            err_sel_q, err_sel_d;

    logic                            tail_s;
    logic                            fire_s;
    logic                            hit_s;

    assign tail_s = dly_q[dly_depth-1];
    assign fire_s = pt_valid & pt_ready_q;

    // Next-state, accumulation and registered-output computation.
    always_comb begin
        state_d        = state_q;
        num_d          = num_q;
        issued_d       = issued_q;
        dly_d          = {dly_q[dly_depth-2:0], 1'b0};
        pipe_in_data_d = pipe_in_data_q;
        acc_sum_d      = acc_sum_q;
        acc_count_d    = acc_count_q;
        pt_ready_d     = pt_ready_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        hit_s          = 1'b0;

        // A qualified result retires whether or not its index is legal.
        retired_d = retired_q + (tail_s ? cnt_one : cnt_zero);
        err_sel_d = err_sel_q | (tail_s & (pipe_sel > sel_max));

        for (int k = 0; k < 3; k++) begin
            hit_s = tail_s & (pipe_sel == centroid_id_width'(k));
            acc_count_d[k*count_width +: count_width] =
                acc_count_q[k*count_width +: count_width] + (hit_s ? cnt_one : cnt_zero);
            for (int d = 0; d < 4; d++) begin
                acc_sum_d[(k*4+d)*sum_width +: sum_width] =
                    acc_sum_q[(k*4+d)*sum_width +: sum_width] +
                    (hit_s ? {{count_width{1'b0}}, pipe_out_data[d*input_data_width +: input_data_width]}
                           : sum_zero);
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                pt_ready_d = 1'b0;
                busy_d     = 1'b0;
                if (start) begin
                    num_d       = num_points;
                    issued_d    = cnt_zero;
                    retired_d   = cnt_zero;
                    dly_d       = {dly_depth{1'b0}};
                    acc_sum_d   = {(12*sum_width){1'b0}};
                    acc_count_d = {(3*count_width){1'b0}};
                    err_sel_d   = 1'b0;
                    if (num_points == cnt_zero) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_RUN;
                        busy_d     = 1'b1;
                        pt_ready_d = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                if (fire_s) begin
                    pipe_in_data_d = pt_data;
                    issued_d       = issued_q + cnt_one;
                    dly_d[0]       = 1'b1;
                end else begin
                    issued_d = issued_q;
                end
                if (issued_q == num_q) begin
                    state_d    = ST_DRAIN;
                    pt_ready_d = 1'b0;
                end else begin
                    pt_ready_d = (issued_d != num_q);
                end
            end
            ST_DRAIN: begin
                pt_ready_d = 1'b0;
                if (retired_q == num_q) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                pt_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any pass in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            num_q          <= {count_width{1'b0}};
            issued_q       <= {count_width{1'b0}};
            retired_q      <= {count_width{1'b0}};
            dly_q          <= {dly_depth{1'b0}};
            pipe_in_data_q <= {(4*input_data_width){1'b0}};
            acc_sum_q      <= {(12*sum_width){1'b0}};
            acc_count_q    <= {(3*count_width){1'b0}};
            pt_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_sel_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            num_q          <= num_d;
            issued_q       <= issued_d;
            retired_q      <= retired_d;
            dly_q          <= dly_d;
            pipe_in_data_q <= pipe_in_data_d;
            acc_sum_q      <= acc_sum_d;
            acc_count_q    <= acc_count_d;
            pt_ready_q     <= pt_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_sel_q      <= err_sel_d;
        end
    end

    assign pt_ready     = pt_ready_q;
    assign pipe_in_data = pipe_in_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_sel      = err_sel_q;
    assign acc_sum      = acc_sum_q;
    assign acc_count    = acc_count_q;

endmodule

// File: tb/tb_kmeans_pass_ctrl_k3_d4.sv
// Bench for kmeans_pass_ctrl_k3_d4: a 6-stage nearest-centroid pipeline model
// feeds results back; expected pass results are queued when a pass starts and
// a monitor compares them when done pulses.
module tb_kmeans_pass_ctrl_k3_d4;

    localparam int W  = 16;
    localparam int CW = 16;
    localparam int SW = W + CW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CW-1:0]     num_points = '0;
    logic              pt_valid = 1'b0;
    logic              pt_ready;
    logic [4*W-1:0]    pt_data = '0;
    logic [4*W-1:0]    pipe_in_data;
    logic [4*W-1:0]    pipe_out_data;
    logic [1:0]        pipe_sel;
    logic              busy, done, err_sel;
    logic [12*SW-1:0]  acc_sum;
    logic [3*CW-1:0]   acc_count;

    kmeans_pass_ctrl_k3_d4 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_points(num_points),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .pipe_in_data(pipe_in_data), .pipe_out_data(pipe_out_data),
        .pipe_sel(pipe_sel), .busy(busy), .done(done), .err_sel(err_sel),
        .acc_sum(acc_sum), .acc_count(acc_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Pipeline model: centroids 0, 100, 1000 on every dimension, L1 distance.
    logic       force_en = 1'b0;
    logic [1:0] pm_sel  [6];
    logic [4*W-1:0] pm_data [6];

    initial begin
        for (int i = 0; i < 6; i++) begin
            pm_sel[i]  = 2'd0;
            pm_data[i] = '0;
        end
    end

    function automatic int l1(input logic [4*W-1:0] p, input int c);
        int s = 0;
        for (int d = 0; d < 4; d++) begin
            int v = int'(p[d*W +: W]);
            s += (v > c) ? (v - c) : (c - v);
        end
        return s;
    endfunction

    function automatic logic [1:0] nearest(input logic [4*W-1:0] p);
        int d0 = l1(p, 0);
        int d1 = l1(p, 100);
        int d2 = l1(p, 1000);
        if (force_en && p[W-1:0] == 16'd90) return 2'd3;
        if (d0 <= d1 && d0 <= d2) return 2'd0;
        if (d1 <= d2) return 2'd1;
        return 2'd2;
    endfunction

    always @(posedge clk) begin
        pm_sel[0]  <= nearest(pipe_in_data);
        pm_data[0] <= pipe_in_data;
        for (int i = 1; i < 6; i++) begin
            pm_sel[i]  <= pm_sel[i-1];
            pm_data[i] <= pm_data[i-1];
        end
    end
    assign pipe_sel      = pm_sel[5];
    assign pipe_out_data = pm_data[5];

    // Cycle counter and reference cycle (last fire or accepted start).
    int cyc = 0;
    int ref_cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pt_valid && pt_ready) ref_cyc <= cyc;
        else if (start && !busy) ref_cyc <= cyc;
    end

    typedef struct {
        logic [3*CW-1:0]  cnt;
        logic [12*SW-1:0] sum;
        logic             err;
        int               lat;
    } exp_t;
    exp_t exp_q[$];

    bit busy_seen = 1'b0;

    // Monitor: compare the queued expectation whenever done pulses.
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_seen = 1'b1;
        if (done) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: got done=1 expected no pass");
            end else begin
                e = exp_q.pop_front();
                total++;
                if (acc_count !== e.cnt) begin
                    bad++; $display("FAIL acc_count: got %h expected %h", acc_count, e.cnt);
                end
                total++;
                if (acc_sum !== e.sum) begin
                    bad++; $display("FAIL acc_sum: got %h expected %h", acc_sum, e.sum);
                end
                total++;
                if (err_sel !== e.err) begin
                    bad++; $display("FAIL err_sel: got %0b expected %0b", err_sel, e.err);
                end
                total++;
                if (cyc - ref_cyc != e.lat) begin
                    bad++; $display("FAIL done_latency: got %0d expected %0d", cyc - ref_cyc, e.lat);
                end
            end
        end
    end

    function automatic logic [4*W-1:0] pt(input int v);
        logic [4*W-1:0] p;
        for (int d = 0; d < 4; d++) p[d*W +: W] = W'(v);
        return p;
    endfunction

    function automatic exp_t mk(input int c0, c1, c2, s0, s1, s2, input logic e, input int lat);
        exp_t r;
        r.cnt = {CW'(c2), CW'(c1), CW'(c0)};
        for (int d = 0; d < 4; d++) begin
            r.sum[(0*4+d)*SW +: SW] = SW'(s0);
            r.sum[(1*4+d)*SW +: SW] = SW'(s1);
            r.sum[(2*4+d)*SW +: SW] = SW'(s2);
        end
        r.err = e;
        r.lat = lat;
        return r;
    endfunction

    task automatic start_pass(input int n);
        num_points = CW'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one point until it fires (entered and left at negedge).
    task automatic send(input int v, input bit with_start);
        int guard = 0;
        pt_valid = 1'b1;
        pt_data  = pt(v);
        start    = with_start;
        while (!pt_ready && guard < 50) begin
            @(negedge clk);
            start = 1'b0;
            guard++;
        end
        if (guard >= 50) begin
            total++; bad++;
            $display("FAIL send_timeout: got pt_ready=0 expected 1");
        end
        @(negedge clk);
        pt_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (!done && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done expected done");
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        total++;
        if ({pt_ready, busy, done, err_sel, pipe_in_data, acc_sum, acc_count} !== '0) begin
            bad++; $display("FAIL reset_state: got nonzero outputs expected all 0");
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Three points back-to-back.
        exp_q.push_back(mk(1, 1, 1, 10, 90, 990, 1'b0, 9));
        start_pass(3);
        send(10, 1'b0); send(90, 1'b0); send(990, 1'b0);
        wait_done();

        // Same points with two-cycle stalls between them.
        exp_q.push_back(mk(1, 1, 1, 10, 90, 990, 1'b0, 9));
        start_pass(3);
        send(10, 1'b0); repeat (2) @(negedge clk);
        send(90, 1'b0); repeat (2) @(negedge clk);
        send(990, 1'b0);
        total++;
        if (pt_ready !== 1'b0) begin
            bad++; $display("FAIL ready_after_last: got %0b expected 0", pt_ready);
        end
        wait_done();

        // Empty pass.
        busy_seen = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1'b0, 1));
        start_pass(0);
        wait_done();
        total++;
        if (busy_seen) begin
            bad++; $display("FAIL busy_empty: got busy=1 expected 0");
        end

        // Five identical points; stray starts during RUN and DRAIN.
        exp_q.push_back(mk(5, 0, 0, 25, 0, 0, 1'b0, 9));
        start_pass(5);
        send(5, 1'b1); send(5, 1'b0); send(5, 1'b1); send(5, 1'b0); send(5, 1'b0);
        @(negedge clk);
        start = 1'b1; num_points = CW'(0);
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Illegal centroid index on the second result.
        force_en = 1'b1;
        exp_q.push_back(mk(1, 0, 1, 10, 0, 990, 1'b1, 9));
        start_pass(3);
        send(10, 1'b0); send(90, 1'b0); send(990, 1'b0);
        wait_done();
        force_en = 1'b0;

        // Reset in the middle of RUN, then a fresh single-point pass.
        start_pass(3);
        send(10, 1'b0); send(90, 1'b0);
        rst_n = 1'b0;
        #1;
        total++;
        if ({pt_ready, busy, done, err_sel, pipe_in_data, acc_sum, acc_count} !== '0) begin
            bad++; $display("FAIL reset_midrun: got nonzero outputs expected all 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(mk(1, 0, 0, 10, 0, 0, 1'b0, 9));
        start_pass(1);
        send(10, 1'b0);
        wait_done();

        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL leftover_expect: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kmeans_pass_ctrl_k3_d4.md
Name: kmeans_pass_ctrl_k3_d4

Overview:
- Sequences one k-means assignment pass over the 3-centroid, 4-dimension distance pipeline.
- Accepts points on a valid/ready stream and feeds them into the pipeline input registers.
- Tracks in-flight points with a valid delay line, because the pipeline has no valid signal.
- Accumulates per-centroid coordinate sums and member counts from pipeline results; a downstream divider uses them to compute new centroids. Centroid values are driven to the pipeline externally, not by this block.

Parameters:
- input_data_width, 16, coordinate width (matches pipeline).
- centroid_id_width, 2, width of pipeline selected-centroid index.
- pipe_latency, 6, pipeline cycles from input_data to selected_centroid/output_data.
- count_width, 16, width of num_points and per-centroid counts.
- sum_width, input_data_width+count_width, per-dimension accumulator width (derived; never overridden).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a pass; honoured only in IDLE or DONE.
- num_points  in  count_width  points in this pass; sampled on accepted start.
- pt_valid  in  1  point available.
- pt_ready  out  1  controller accepts a point.
- pt_data  in  4*input_data_width  point, dimension d at [d*W+:W].
- pipe_in_data  out  4*input_data_width  registered point to the pipeline input_data0..3.
- pipe_out_data  in  4*input_data_width  pipeline output_data0..3 (point echo).
- pipe_sel  in  centroid_id_width  pipeline selected_centroid.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse on entry to DONE.
- err_sel  out  1  sticky; a valid result carried pipe_sel greater than 2.
- acc_sum  out  12*sum_width  sum for centroid k, dimension d at index k*4+d.
- acc_count  out  3*count_width  member count for centroid k at index k.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - pt_ready, busy, done, err_sel = 0.
  - pipe_in_data, acc_sum, acc_count, issued and retired counters, and valid delay line all cleared.
- Reset mid-pass aborts the pass; no partial results are kept.
- States:
  - IDLE: pt_ready=0. On start: clear accumulators, counters and err_sel, latch num_points. Go to RUN, or to DONE if num_points==0.
  - RUN: pt_ready = (issued != num_points). A fire (pt_valid && pt_ready) registers pt_data into pipe_in_data, increments issued, and shifts 1 into the delay line; otherwise shift 0. pipe_in_data holds its value when there is no fire. When issued reaches num_points (on the cycle after the last fire), go to DRAIN.
  - DRAIN: pt_ready=0; delay line keeps shifting 0. When retired == num_points, go to DONE.
  - DONE: done=1 for the entry cycle only. acc_sum and acc_count are held stable until the next accepted start. start behaves as in IDLE.
- start while in RUN or DRAIN is ignored.
- The delay line is pipe_latency+1 deep: one cycle for the pipe_in_data register plus pipe_latency. Its tail bit qualifies pipe_sel and pipe_out_data.
- Tail bit = 1:
  - If pipe_sel <= 2: acc_sum[pipe_sel][d] += zero-extended pipe_out_data[d] for all d, and acc_count[pipe_sel] += 1.
  - If pipe_sel == 3: no accumulation and err_sel <= 1.
  - retired increments in both cases.
- Arithmetic is unsigned. sum_width guarantees no overflow for up to 2^count_width-1 points of maximum value. Counts never exceed num_points.
- Throughput: one point per cycle when pt_valid is held high.
- Pass latency from the last fire to done = pipe_latency + 2 cycles.
- pt_valid stalls insert bubbles (delay-line zeros) with no effect on results.

Test Plan:
- Setup: bench pipeline model with centroids c0=(0,0,0,0), c1=(100,100,100,100), c2=(1000,1000,1000,1000). start with num_points=3; points (10,10,10,10), (90,90,90,90), (990,990,990,990) back-to-back → done 8 cycles after the last fire; acc_count=(1,1,1); acc_sum k0 dims=10, k1=90, k2=990; err_sel=0.
- Same 3 points with pt_valid low for 2 cycles between points → identical sums and counts; pt_ready deasserts after the third fire.
- start with num_points=0 → done pulses the cycle after start, all accumulators 0, busy never high.
- 5 points all (5,5,5,5) → acc_count=(5,0,0), acc_sum k0 dims=25; start pulses during RUN and DRAIN are ignored.
- Force pipe_sel=3 on the second of 3 results → err_sel=1, total counts=2, retired still reaches 3, done still pulses.
- Assert rst_n low mid-RUN after 2 fires → all outputs 0 immediately; the next start with num_points=1, point (10,10,10,10) gives acc_count=(1,0,0) with no stale contributions.
